modulus_down_counter: RTL and testbench

//   Loadable modulus DOWN counter: counts LIMIT..0, then wraps back to LIMIT
//   (auto-reload) or stops at 0 (one-shot). Complements the modulus up

---
 rtl/modulus_down_counter_if.sv | 26 ++
 rtl/modulus_down_counter.sv | 118 +++++++++++
 tb/tb_modulus_down_counter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modulus_down_counter_if.sv
// Control/status bundle for the modulus down counter.
// Master drives load/enable/mode, slave returns count and flags.
interface modulus_down_counter_if #(
    parameter int LIMIT = 12
) ();
    localparam int W = $clog2(LIMIT + 1);

    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         mode;
    logic [W-1:0] Q;
    logic         tc;
    logic         wrap;
    logic         busy;

    modport master (
        output en, load, load_val, mode,
        input  Q, tc, wrap, busy
    );

    modport slave (
        input  en, load, load_val, mode,
        output Q, tc, wrap, busy
    );
endinterface

// File: rtl/modulus_down_counter.sv
// Loadable modulus down counter, auto-reload or one-shot, with wrap pulse.
// Optional step prescaler enabled by defining MODDN_PRESCALE_EN.
module modulus_down_counter #(
    parameter int LIMIT    = 12,
    parameter int W        = $clog2(LIMIT + 1),
    parameter int PRESCALE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    modulus_down_counter_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [W-1:0] MAXV = W'(LIMIT);

    state_t       state, state_n;
    logic [W-1:0] q, q_n;
    logic         wrap, wrap_n;
    logic         busy, busy_n;
    logic         step;
    logic [W-1:0] start_val;

`ifdef MODDN_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

    logic [PW-1:0] pre, pre_n;

    // Prescaler advances only on enabled RUN cycles; load restarts it.
    always_comb begin
        pre_n = pre;
        step  = 1'b0;
        if (bus.load) begin
            pre_n = '0;
        end else if (state == RUN && bus.en) begin
            if (pre == PTOP) begin
                pre_n = '0;
                step  = 1'b1;
            end else begin
                pre_n = pre + 1'b1;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) pre <= '0;
        else       pre <= pre_n;
    end
`else
    // Every enabled cycle is a step when no prescaler is built in.
    always_comb begin
        step = bus.en && (PRESCALE > 0);
    end
`endif

    assign start_val = (bus.load_val > MAXV) ? MAXV : bus.load_val;

    // Next-state, next-count and flag decode; load outranks counting.
    always_comb begin
        state_n = state;
        q_n     = q;
        wrap_n  = 1'b0;
        if (bus.load) begin
            q_n     = start_val;
            state_n = RUN;
        end else begin
            unique case (state)
                IDLE: begin
                end
                RUN: begin
                    if (step) begin
                        if (q != '0) begin
                            q_n = q - 1'b1;
                        end else if (!bus.mode) begin
                            q_n    = MAXV;
                            wrap_n = 1'b1;
                        end else begin
                            state_n = EXPIRED;
                            wrap_n  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                end
                default: begin
                    state_n = IDLE;
                    q_n     = MAXV;
                end
            endcase
        end
        busy_n = (state_n == RUN);
    end

    // State, count and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= MAXV;
            wrap  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            wrap  <= wrap_n;
            busy  <= busy_n;
        end
    end

    assign bus.Q    = q;
    assign bus.tc   = (q == '0);
    assign bus.wrap = wrap;
    assign bus.busy = busy;
endmodule

// File: tb/tb_modulus_down_counter.sv
// Bench for modulus_down_counter (default build, LIMIT=12).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_modulus_down_counter;
    localparam int LIMIT = 12;
    localparam int W     = $clog2(LIMIT + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // model: count, phase (0 idle, 1 running, 2 expired), wrap pulse
    int   m_q   = LIMIT;
    int   m_ph  = 0;
    bit   m_wrap = 1'b0;

    modulus_down_counter_if #(.LIMIT(LIMIT)) bus ();

    modulus_down_counter #(.LIMIT(LIMIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        int  lv;
        bit  w;
        w = 1'b0;
        if (reset) begin
            m_q  = LIMIT;
            m_ph = 0;
        end else if (bus.load) begin
            lv   = int'(bus.load_val);
            m_q  = (lv > LIMIT) ? LIMIT : lv;
            m_ph = 1;
        end else if (m_ph == 1 && bus.en) begin
            if (m_q > 0) begin
                m_q = m_q - 1;
            end else begin
                w = 1'b1;
                if (bus.mode) m_ph = 2;
                else          m_q  = LIMIT;
            end
        end
        m_wrap = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mode     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.Q !== 4'd12 || bus.busy !== 1'b0 ||
            bus.wrap !== 1'b0 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_state Q=%0d busy=%b wrap=%b tc=%b want 12/0/0/0",
                     bus.Q, bus.busy, bus.wrap, bus.tc);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.Q !== 4'd12 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_en_only Q=%0d busy=%b want 12/0", bus.Q, bus.busy);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_auto_reload();
        int nwrap = 0;
        int last  = -1;
        int gap   = 0;
        bus.load = 1'b1; bus.load_val = 4'd12; bus.mode = 1'b0; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.Q !== 4'd12 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_load Q=%0d busy=%b want 12/1", bus.Q, bus.busy);
        end
        for (int i = 1; i <= 26; i++) begin
            tick();
            checks++;
            if (bus.Q !== W'(m_q) || bus.tc !== (m_q == 0) ||
                bus.wrap !== m_wrap) begin
                errors++;
                $display("FAIL reload_cyc%0d Q=%0d tc=%b wrap=%b want %0d/%b/%b",
                         i, bus.Q, bus.tc, bus.wrap, m_q, m_q == 0, m_wrap);
            end
            if (bus.wrap === 1'b1) begin
                if (last >= 0) gap = i - last;
                last = i;
                nwrap++;
            end
        end
        checks++;
        if (nwrap != 2 || gap != 13) begin
            errors++;
            $display("FAIL reload_spacing pulses=%0d gap=%0d want 2/13", nwrap, gap);
        end
    endtask

    task automatic test_one_shot();
        int nwrap = 0;
        bus.load = 1'b1; bus.load_val = 4'd3; bus.mode = 1'b1; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wrap === 1'b1) nwrap++;
            checks++;
            if (bus.Q !== W'(m_q) || bus.busy !== (m_ph == 1) ||
                bus.wrap !== m_wrap) begin
                errors++;
                $display("FAIL oneshot_cyc%0d Q=%0d busy=%b wrap=%b want %0d/%b/%b",
                         i, bus.Q, bus.busy, bus.wrap, m_q, m_ph == 1, m_wrap);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.wrap === 1'b1) nwrap++;
        end
        checks++;
        if (bus.Q !== 4'd0 || bus.busy !== 1'b0 ||
            bus.tc !== 1'b1 || nwrap != 1) begin
            errors++;
            $display("FAIL oneshot_hold Q=%0d busy=%b tc=%b pulses=%0d want 0/0/1/1",
                     bus.Q, bus.busy, bus.tc, nwrap);
        end
        bus.load = 1'b1; bus.load_val = 4'd5;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.Q !== 4'd5 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_reload Q=%0d busy=%b want 5/1", bus.Q, bus.busy);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_clamp_priority();
        bus.mode = 1'b0;
        bus.load = 1'b1; bus.load_val = 4'd15; bus.en = 1'b0;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.Q !== 4'd12) begin
            errors++;
            $display("FAIL clamp Q=%0d want 12", bus.Q);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.Q !== 4'd7) begin
            errors++;
            $display("FAIL count_to_7 Q=%0d want 7", bus.Q);
        end
        bus.load = 1'b1; bus.load_val = 4'd9;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.Q !== 4'd9) begin
            errors++;
            $display("FAIL load_over_en Q=%0d want 9", bus.Q);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.Q !== 4'd9 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL en_low_hold%0d Q=%0d busy=%b want 9/1",
                         i, bus.Q, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b0;
        bus.load = 1'b1; bus.load_val = 4'd8; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.Q !== 4'd4) begin
            errors++;
            $display("FAIL mid_pre Q=%0d want 4", bus.Q);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.Q !== 4'd12 || bus.busy !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset Q=%0d busy=%b wrap=%b want 12/0/0",
                     bus.Q, bus.busy, bus.wrap);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.Q !== 4'd12 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle Q=%0d busy=%b want 12/0", bus.Q, bus.busy);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 49) == 0);
            bus.load     = ($urandom_range(0, 9) == 0);
            bus.load_val = W'($urandom_range(0, 15));
            bus.en       = ($urandom_range(0, 3) != 0);
            bus.mode     = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if (bus.Q !== W'(m_q) || bus.tc !== (m_q == 0) ||
                bus.wrap !== m_wrap || bus.busy !== (m_ph == 1)) begin
                errors++;
                $display("FAIL rand%0d Q=%0d tc=%b wrap=%b busy=%b want %0d/%b/%b/%b",
                         i, bus.Q, bus.tc, bus.wrap, bus.busy,
                         m_q, m_q == 0, m_wrap, m_ph == 1);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_clamp_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
